// File: rtl/cache_writeback_buffer.sv
// cache_writeback_buffer
//   Buffers dirty victim lines and drains each one to the bus as a burst of
//   BEATLEN-wide beats. Storage is a DEPTH-entry circular FIFO. Each occupied
//   entry can be snooped by line address so the fill path does not refetch a
//   line before its writeback has finished.
//   Optional feature macro: WBBUF_FORWARD_EN. When it is defined, o_snoop_line
//   carries the youngest matching buffered line. When it is not defined,
//   o_snoop_line is tied to zero.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | buffer empty, no beat offered to the bus
//   S_BURST | head entry being drained, one beat offered per cycle
module cache_writeback_buffer #(
   parameter int LINELEN = 512,
   parameter int BEATLEN = 64,
   parameter int PALEN   = 56,
   parameter int DEPTH   = 2
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_evict_valid,
   output logic               o_evict_ready,
   input  logic [PALEN-1:0]   i_evict_adr,
   input  logic [LINELEN-1:0] i_evict_line,
   output logic               o_bus_valid,
   input  logic               i_bus_ready,
   output logic [PALEN-1:0]   o_bus_adr,
   output logic [BEATLEN-1:0] o_bus_data,
   output logic               o_bus_last,
   input  logic [PALEN-1:0]   i_snoop_adr,
   output logic               o_snoop_hit,
   output logic [LINELEN-1:0] o_snoop_line
);

   localparam int BEATS   = LINELEN / BEATLEN;
   localparam int LINEOFF = $clog2(LINELEN / 8);
   localparam int TAGW    = PALEN - LINEOFF;
   localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW      = $clog2(DEPTH + 1);

   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
   localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [TAGW-1:0]    r_tag  [DEPTH];
   logic [LINELEN-1:0] r_line [DEPTH];
   logic [DEPTH-1:0]   r_vld;
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic [BCW-1:0]     r_beat_cnt;

   logic               w_enq;
   logic               w_beat_acc;
   logic               w_last_acc;
   logic [CW-1:0]      w_count_nxt;
   logic [TAGW-1:0]    w_snoop_tag;
   logic [LINELEN-1:0] w_head_line;
   logic [PALEN-1:0]   w_beat_off;
   logic               w_unused_lowbits;

   // The low address bits select a byte within the line, so the buffer never uses them.
   assign w_unused_lowbits = ^{i_evict_adr[LINEOFF-1:0], i_snoop_adr[LINEOFF-1:0]};

   // The buffer is only ready when it has a free slot. A slot freed by the
   // current last beat becomes usable in the next cycle, not this one.
   assign o_evict_ready = (r_count != FULL_CNT);
   assign w_enq         = i_evict_valid & o_evict_ready;
   assign w_beat_acc    = o_bus_valid & i_bus_ready;
   assign w_last_acc    = w_beat_acc & (r_beat_cnt == LAST_BEAT);
   assign w_snoop_tag   = i_snoop_adr[PALEN-1:LINEOFF];
   assign w_head_line   = r_line[r_rd_ptr];
   assign w_beat_off    = PALEN'(r_beat_cnt) * PALEN'(BEATLEN / 8);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Occupancy after this cycle's enqueue and dequeue.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_enq, w_last_acc})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Line storage is written on enqueue only. It has no reset because the valid bits mark which entries are live.
   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_tag[r_wr_ptr]  <= i_evict_adr[PALEN-1:LINEOFF];
         r_line[r_wr_ptr] <= i_evict_line;
      end
   end

   // Pointers, occupancy, per-entry valid bits and the beat counter.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_vld      <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_beat_cnt <= '0;
      end else begin
         if (w_enq) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_last_acc) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= ptr_inc(r_rd_ptr);
         end
         if (w_beat_acc) begin
            r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
         end
         r_count <= w_count_nxt;
      end
   end

   // Drain FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Drain FSM next state. A queued line starts its burst in the cycle after it is accepted, with no gap between back-to-back lines.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_count_nxt != '0) w_state_nxt = S_BURST;
         S_BURST: if (w_last_acc && (w_count_nxt == '0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Drain FSM outputs. The beat is selected by the counter, so it stays stable while the bus stalls.
   always_comb begin
      o_bus_valid = 1'b0;
      o_bus_last  = 1'b0;
      o_bus_adr   = {r_tag[r_rd_ptr], {LINEOFF{1'b0}}} + w_beat_off;
      o_bus_data  = w_head_line[r_beat_cnt*BEATLEN +: BEATLEN];
      if (r_state == S_BURST) begin
         o_bus_valid = 1'b1;
         o_bus_last  = (r_beat_cnt == LAST_BEAT);
      end
   end

   // Snoop compare against every live entry. The scan runs from oldest to youngest, so the youngest match wins.
   always_comb begin
      o_snoop_hit  = 1'b0;
      o_snoop_line = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_vld[(int'(r_rd_ptr) + k) % DEPTH] &&
             (r_tag[(int'(r_rd_ptr) + k) % DEPTH] == w_snoop_tag)) begin
            o_snoop_hit  = 1'b1;
`ifdef WBBUF_FORWARD_EN
            o_snoop_line = r_line[(int'(r_rd_ptr) + k) % DEPTH];
`else
            o_snoop_line = '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed and random self-checking bench for cache_writeback_buffer (default parameters).
module tb_cache_writeback_buffer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         evict_valid;
   logic         evict_ready;
   logic [55:0]  evict_adr;
   logic [511:0] evict_line;
   logic         bus_valid;
   logic         bus_ready;
   logic [55:0]  bus_adr;
   logic [63:0]  bus_data;
   logic         bus_last;
   logic [55:0]  snoop_adr;
   logic         snoop_hit;
   logic [511:0] snoop_line;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [55:0]  adr;
      logic [511:0] line;
   } ent_t;

   cache_writeback_buffer dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_evict_valid (evict_valid),
      .o_evict_ready (evict_ready),
      .i_evict_adr   (evict_adr),
      .i_evict_line  (evict_line),
      .o_bus_valid   (bus_valid),
      .i_bus_ready   (bus_ready),
      .o_bus_adr     (bus_adr),
      .o_bus_data    (bus_data),
      .o_bus_last    (bus_last),
      .i_snoop_adr   (snoop_adr),
      .o_snoop_hit   (snoop_hit),
      .o_snoop_line  (snoop_line)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] mk_line(input logic [31:0] seed);
      logic [511:0] l;
      for (int i = 0; i < 8; i++) l[i*64 +: 64] = {seed, 32'(i)};
      return l;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; evict_valid = 1'b0; evict_adr = '0; evict_line = '0;
      bus_ready = 1'b0; snoop_adr = '0;
      tick(); tick();
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus_valid); else n_pass++;
      n_checks++; if (bus_last !== 1'b0) $display("FAIL reset_last got %b want 0", bus_last); else n_pass++;
      n_checks++; if (snoop_hit !== 1'b0) $display("FAIL reset_snoop got %b want 0", snoop_hit); else n_pass++;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", evict_ready); else n_pass++;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_line();
      logic [511:0] l;
      l = mk_line(32'hA1A1_0001);
      bus_ready = 1'b1; evict_adr = 56'h1000; evict_line = l; evict_valid = 1'b1;
      #1;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL single_ready0 got %b want 1", evict_ready); else n_pass++;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL single_valid0 got %b want 0", bus_valid); else n_pass++;
      tick();
      evict_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++; if (bus_valid !== 1'b1) $display("FAIL single_valid beat %0d got %b want 1", i, bus_valid); else n_pass++;
         n_checks++; if (bus_adr !== 56'h1000 + 56'(i*8)) $display("FAIL single_adr beat %0d got %h want %h", i, bus_adr, 56'h1000 + 56'(i*8)); else n_pass++;
         n_checks++; if (bus_data !== {32'hA1A1_0001, 32'(i)}) $display("FAIL single_data beat %0d got %h want %h", i, bus_data, {32'hA1A1_0001, 32'(i)}); else n_pass++;
         n_checks++; if (bus_last !== (i == 7)) $display("FAIL single_last beat %0d got %b want %b", i, bus_last, (i == 7)); else n_pass++;
         tick();
      end
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL single_valid_end got %b want 0", bus_valid); else n_pass++;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL single_ready_end got %b want 1", evict_ready); else n_pass++;
   endtask

   task automatic test_stall();
      logic [3:0] pat;
      int idx;
      pat = 4'b1001;
      bus_ready = 1'b0; evict_adr = 56'h3000; evict_line = mk_line(32'hB2B2_0002); evict_valid = 1'b1;
      tick();
      evict_valid = 1'b0;
      idx = 0;
      for (int c = 0; c < 40 && idx < 8; c++) begin
         bus_ready = pat[c % 4];
         #1;
         n_checks++; if (bus_valid !== 1'b1) $display("FAIL stall_valid cyc %0d got %b want 1", c, bus_valid); else n_pass++;
         n_checks++; if (bus_adr !== 56'h3000 + 56'(idx*8)) $display("FAIL stall_adr cyc %0d got %h want %h", c, bus_adr, 56'h3000 + 56'(idx*8)); else n_pass++;
         n_checks++; if (bus_data !== {32'hB2B2_0002, 32'(idx)}) $display("FAIL stall_data cyc %0d got %h want %h", c, bus_data, {32'hB2B2_0002, 32'(idx)}); else n_pass++;
         n_checks++; if (bus_last !== (idx == 7)) $display("FAIL stall_last cyc %0d got %b want %b", c, bus_last, (idx == 7)); else n_pass++;
         if (bus_ready) idx++;
         tick();
      end
      n_checks++; if (idx != 8) $display("FAIL stall_timeout beats got %0d want 8", idx); else n_pass++;
      bus_ready = 1'b1;
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL stall_valid_end got %b want 0", bus_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [55:0]  base [3];
      logic [31:0]  seed [3];
      int ln, bt;
      logic exp_rdy;
      base[0] = 56'h4000; base[1] = 56'h5000; base[2] = 56'h6000;
      seed[0] = 32'hC1; seed[1] = 32'hC2; seed[2] = 32'hC3;
      bus_ready = 1'b0;
      evict_adr = base[0]; evict_line = mk_line(seed[0]); evict_valid = 1'b1;
      #1;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", evict_ready); else n_pass++;
      tick();
      evict_adr = base[1]; evict_line = mk_line(seed[1]);
      #1;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL b2b_ready2 got %b want 1", evict_ready); else n_pass++;
      tick();
      evict_adr = base[2]; evict_line = mk_line(seed[2]);
      #1;
      n_checks++; if (evict_ready !== 1'b0) $display("FAIL b2b_ready3 got %b want 0", evict_ready); else n_pass++;
      tick();
      for (int cyc = 0; cyc < 24; cyc++) begin
         bus_ready = 1'b1;
         evict_valid = (cyc <= 8);
         ln = cyc / 8; bt = cyc % 8;
         exp_rdy = (cyc == 8) || (cyc >= 16);
         #1;
         n_checks++; if (evict_ready !== exp_rdy) $display("FAIL b2b_ready cyc %0d got %b want %b", cyc, evict_ready, exp_rdy); else n_pass++;
         n_checks++; if (bus_valid !== 1'b1) $display("FAIL b2b_valid cyc %0d got %b want 1", cyc, bus_valid); else n_pass++;
         n_checks++; if (bus_adr !== base[ln] + 56'(bt*8)) $display("FAIL b2b_adr cyc %0d got %h want %h", cyc, bus_adr, base[ln] + 56'(bt*8)); else n_pass++;
         n_checks++; if (bus_data !== {seed[ln], 32'(bt)}) $display("FAIL b2b_data cyc %0d got %h want %h", cyc, bus_data, {seed[ln], 32'(bt)}); else n_pass++;
         n_checks++; if (bus_last !== (bt == 7)) $display("FAIL b2b_last cyc %0d got %b want %b", cyc, bus_last, (bt == 7)); else n_pass++;
         tick();
      end
      evict_valid = 1'b0;
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL b2b_valid_end got %b want 0", bus_valid); else n_pass++;
   endtask

   task automatic test_snoop();
      logic [511:0] l;
      logic         exp_hit;
      logic [511:0] exp_line;
      l = mk_line(32'hD4D4_0004);
      bus_ready = 1'b1; snoop_adr = 56'h2010;
      evict_adr = 56'h2000; evict_line = l; evict_valid = 1'b1;
      #1;
      n_checks++; if (snoop_hit !== 1'b0) $display("FAIL snoop_enq_cycle got %b want 0", snoop_hit); else n_pass++;
      tick();
      evict_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         snoop_adr = (i == 4) ? 56'h2040 : 56'h2010;
         exp_hit = (i != 4);
`ifdef WBBUF_FORWARD_EN
         exp_line = exp_hit ? l : '0;
`else
         exp_line = '0;
`endif
         #1;
         n_checks++; if (snoop_hit !== exp_hit) $display("FAIL snoop_hit beat %0d got %b want %b", i, snoop_hit, exp_hit); else n_pass++;
         n_checks++; if (snoop_line !== exp_line) $display("FAIL snoop_line beat %0d got %h want %h", i, snoop_line, exp_line); else n_pass++;
         tick();
      end
      snoop_adr = 56'h2010;
      #1;
      n_checks++; if (snoop_hit !== 1'b0) $display("FAIL snoop_after_drain got %b want 0", snoop_hit); else n_pass++;
      n_checks++; if (snoop_line !== '0) $display("FAIL snoop_line_after got %h want 0", snoop_line); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      bus_ready = 1'b1;
      evict_adr = 56'h7000; evict_line = mk_line(32'hE5); evict_valid = 1'b1;
      tick();
      evict_adr = 56'h8000; evict_line = mk_line(32'hE6);
      tick();
      evict_valid = 1'b0;
      tick(); tick();
      #1;
      n_checks++; if (bus_adr !== 56'h7018) $display("FAIL rst_mid_beat3_adr got %h want 7018", bus_adr); else n_pass++;
      reset_n = 1'b0;
      tick();
      snoop_adr = 56'h7000;
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", bus_valid); else n_pass++;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", evict_ready); else n_pass++;
      n_checks++; if (snoop_hit !== 1'b0) $display("FAIL rst_mid_snoopA got %b want 0", snoop_hit); else n_pass++;
      snoop_adr = 56'h8000;
      #1;
      n_checks++; if (snoop_hit !== 1'b0) $display("FAIL rst_mid_snoopB got %b want 0", snoop_hit); else n_pass++;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++; if (bus_valid !== 1'b0) $display("FAIL rst_mid_quiet cyc %0d got %b want 0", i, bus_valid); else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      ent_t q[$];
      ent_t e;
      int mb;
      logic exp_rdy, exp_vld, enq;
      logic [55:0]  exp_adr;
      logic [63:0]  exp_data;
      mb = 0;
      for (int cyc = 0; cyc < 1040; cyc++) begin
         if (cyc < 1000) begin
            evict_valid = ($urandom_range(0, 1) == 1);
            bus_ready   = ($urandom_range(0, 2) != 0);
         end else begin
            evict_valid = 1'b0;
            bus_ready   = 1'b1;
         end
         e.adr = 56'({$urandom(), $urandom()});
         e.adr[5:0] = 6'b0;
         for (int i = 0; i < 16; i++) e.line[i*32 +: 32] = $urandom();
         evict_adr = e.adr; evict_line = e.line;
         exp_rdy = (q.size() != 2);
         exp_vld = (q.size() != 0);
         #1;
         n_checks++; if (evict_ready !== exp_rdy) $display("FAIL rand_ready cyc %0d got %b want %b", cyc, evict_ready, exp_rdy); else n_pass++;
         n_checks++; if (bus_valid !== exp_vld) $display("FAIL rand_valid cyc %0d got %b want %b", cyc, bus_valid, exp_vld); else n_pass++;
         if (exp_vld) begin
            exp_adr  = q[0].adr + 56'(mb*8);
            exp_data = q[0].line[mb*64 +: 64];
            n_checks++; if (bus_adr !== exp_adr) $display("FAIL rand_adr cyc %0d got %h want %h", cyc, bus_adr, exp_adr); else n_pass++;
            n_checks++; if (bus_data !== exp_data) $display("FAIL rand_data cyc %0d got %h want %h", cyc, bus_data, exp_data); else n_pass++;
            n_checks++; if (bus_last !== (mb == 7)) $display("FAIL rand_last cyc %0d got %b want %b", cyc, bus_last, (mb == 7)); else n_pass++;
         end
         enq = evict_valid && exp_rdy;
         if (exp_vld && bus_ready) begin
            if (mb == 7) begin
               void'(q.pop_front());
               mb = 0;
            end else begin
               mb++;
            end
         end
         if (enq) q.push_back(e);
         tick();
      end
      #1;
      n_checks++; if (bus_valid !== 1'b0) $display("FAIL rand_drain_valid got %b want 0", bus_valid); else n_pass++;
      n_checks++; if (evict_ready !== 1'b1) $display("FAIL rand_drain_ready got %b want 1", evict_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_stall();
      test_back_to_back();
      test_snoop();
      test_reset_mid_burst();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
